// File: rtl/snow64_instr_cache_param.sv
// ---------------------------------------------------------------------------
// snow64_instr_cache_param
//
// Direct-mapped instruction cache between the fetch stage and the memory
// arbiter. Line width, line count, instruction width and address width are
// parameters. Supports a sequential invalidate-all (flush) walk, a busy
// indication, and a flush request that is deferred while a line fill is
// outstanding.
//
// Address split (LSB -> MSB): dont_care | line_index | arr_index | tag
//
// Ports:
//   clk                  clock
//   rst                  synchronous active-high reset
//   in_req_read_req      fetch request
//   in_req_read_addr     fetch byte address
//   in_flush_req         invalidate-all request (single-cycle pulse)
//   in_mem_access_valid  fill data valid
//   in_mem_access_data   fill line data
//   out_req_read_valid   instruction valid (one-cycle pulse)
//   out_req_read_instr   fetched instruction (holds its last value)
//   out_busy             cache cannot accept a fetch this cycle
//   out_mem_access_req   line fill request
//   out_mem_access_addr  line-aligned fill address
// ---------------------------------------------------------------------------
module snow64_instr_cache_param #(
  parameter int WIDTH__ADDR         = 64,
  parameter int WIDTH__INSTR        = 32,
  parameter int WIDTH__LINE_DATA    = 256,
  parameter int ARR_SIZE__NUM_LINES = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_req_read_req,
  input  logic [WIDTH__ADDR-1:0]      in_req_read_addr,
  input  logic                        in_flush_req,
  input  logic                        in_mem_access_valid,
  input  logic [WIDTH__LINE_DATA-1:0] in_mem_access_data,
  output logic                        out_req_read_valid,
  output logic [WIDTH__INSTR-1:0]     out_req_read_instr,
  output logic                        out_busy,
  output logic                        out_mem_access_req,
  output logic [WIDTH__ADDR-1:0]      out_mem_access_addr
);

  // -------------------------------------------------------------------------
  // Derived geometry
  // -------------------------------------------------------------------------
  localparam int DC_W   = $clog2(WIDTH__INSTR / 8);
  localparam int WORDS  = WIDTH__LINE_DATA / WIDTH__INSTR;
  localparam int LI_W   = $clog2(WORDS);
  // A line holding a single instruction has no line_index field; keep the
  // select signal one bit wide so it can still be declared.
  localparam int LI_W_S = (LI_W > 0) ? LI_W : 1;
  localparam int AI_W   = $clog2(ARR_SIZE__NUM_LINES);
  localparam int TAG_W  = WIDTH__ADDR - DC_W - LI_W - AI_W;

  localparam logic [WIDTH__ADDR-1:0] OFFS_MASK = WIDTH__ADDR'(WIDTH__LINE_DATA / 8 - 1);
  localparam logic [WIDTH__ADDR-1:0] LI_MASK   = WIDTH__ADDR'(WORDS - 1);
  localparam logic [AI_W-1:0]        LAST_IDX  = AI_W'(ARR_SIZE__NUM_LINES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitForMem,
    StFlush
  } state_t;

  // -------------------------------------------------------------------------
  // State and storage
  // -------------------------------------------------------------------------
  state_t                      r_state;
  state_t                      w_state_next;
  logic                        r_flush_pending;
  logic [AI_W-1:0]             r_flush_cnt;
  logic [WIDTH__ADDR-1:0]      r_req_addr;
  logic                        r_read_valid;
  logic [WIDTH__INSTR-1:0]     r_read_instr;

  // Tag and data arrays carry no reset; only the valid flops do.
  logic [TAG_W-1:0]            r_tag_mem  [ARR_SIZE__NUM_LINES];
  logic [WIDTH__LINE_DATA-1:0] r_data_mem [ARR_SIZE__NUM_LINES];
  logic [ARR_SIZE__NUM_LINES-1:0] w_valid;

  // -------------------------------------------------------------------------
  // Address decode: incoming request and registered (fill) request
  // -------------------------------------------------------------------------
  logic [AI_W-1:0]             w_req_arr_idx;
  logic [TAG_W-1:0]            w_req_tag;
  logic [LI_W_S-1:0]           w_req_line_idx;
  logic [AI_W-1:0]             w_fill_arr_idx;
  logic [TAG_W-1:0]            w_fill_tag;
  logic [LI_W_S-1:0]           w_fill_line_idx;

  assign w_req_arr_idx   = in_req_read_addr[DC_W+LI_W +: AI_W];
  assign w_req_tag       = in_req_read_addr[WIDTH__ADDR-1 -: TAG_W];
  assign w_req_line_idx  = LI_W_S'((in_req_read_addr >> DC_W) & LI_MASK);

  assign w_fill_arr_idx  = r_req_addr[DC_W+LI_W +: AI_W];
  assign w_fill_tag      = r_req_addr[WIDTH__ADDR-1 -: TAG_W];
  assign w_fill_line_idx = LI_W_S'((r_req_addr >> DC_W) & LI_MASK);

  // -------------------------------------------------------------------------
  // Lookup (asynchronous array read so a hit can be answered next cycle and a
  // miss can already be in StWaitForMem next cycle)
  // -------------------------------------------------------------------------
  logic [WIDTH__LINE_DATA-1:0] w_line_rd;
  logic [TAG_W-1:0]            w_tag_rd;
  logic                        w_hit;
  logic [WIDTH__INSTR-1:0]     w_hit_instr;
  logic [WIDTH__INSTR-1:0]     w_fill_instr;

  assign w_line_rd    = r_data_mem[w_req_arr_idx];
  assign w_tag_rd     = r_tag_mem[w_req_arr_idx];
  assign w_hit        = w_valid[w_req_arr_idx] && (w_tag_rd == w_req_tag);
  assign w_hit_instr  = w_line_rd[int'(w_req_line_idx) * WIDTH__INSTR +: WIDTH__INSTR];
  assign w_fill_instr = in_mem_access_data[int'(w_fill_line_idx) * WIDTH__INSTR +: WIDTH__INSTR];

  // -------------------------------------------------------------------------
  // Control qualifiers
  // -------------------------------------------------------------------------
  logic w_accept;
  logic w_fill_done;
  logic w_flush_start;
  logic w_flush_active;

  // A flush in the same cycle as a read wins; the read is dropped.
  assign w_accept       = in_req_read_req && !out_busy && !in_flush_req;
  assign w_fill_done    = (r_state == StWaitForMem) && in_mem_access_valid;
  assign w_flush_active = (r_state == StFlush);
  assign w_flush_start  = (w_state_next == StFlush) && (r_state != StFlush);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next       = r_state;
    out_busy           = (r_state != StIdle) || r_flush_pending;
    out_mem_access_req = (r_state == StWaitForMem);

    case (r_state)
      StIdle: begin
        if (in_flush_req) begin
          w_state_next = StFlush;
        end else if (w_accept && !w_hit) begin
          w_state_next = StWaitForMem;
        end
      end
      StWaitForMem: begin
        // A flush arriving together with the fill data is treated as pending.
        if (in_mem_access_valid) begin
          w_state_next = (r_flush_pending || in_flush_req) ? StFlush : StIdle;
        end
      end
      StFlush: begin
        if (r_flush_cnt == LAST_IDX) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Deferred flush flag and flush walk counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_pending <= 1'b0;
    end else if (r_state == StWaitForMem) begin
      if (w_fill_done) begin
        r_flush_pending <= 1'b0;
      end else if (in_flush_req) begin
        r_flush_pending <= 1'b1;
      end
    end else begin
      r_flush_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (w_flush_start) begin
      r_flush_cnt <= '0;
    end else if (w_flush_active) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-line valid flops: set by a fill, cleared by the flush walk
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < ARR_SIZE__NUM_LINES; gi++) begin : g_line
      logic r_valid;
      logic w_set;
      logic w_clr;

      assign w_set = w_fill_done && (w_fill_arr_idx == AI_W'(gi));
      assign w_clr = w_flush_active && (r_flush_cnt == AI_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
        end else if (w_clr) begin
          r_valid <= 1'b0;
        end else if (w_set) begin
          r_valid <= 1'b1;
        end
      end

      assign w_valid[gi] = r_valid;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Tag / data arrays
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && w_fill_done) begin
      r_tag_mem[w_fill_arr_idx]  <= w_fill_tag;
      r_data_mem[w_fill_arr_idx] <= in_mem_access_data;
    end
  end

  // -------------------------------------------------------------------------
  // Request address register (also drives the fill address)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_addr <= '0;
    end else if (w_accept) begin
      r_req_addr <= in_req_read_addr;
    end
  end

  assign out_mem_access_addr = r_req_addr & ~OFFS_MASK;

  // -------------------------------------------------------------------------
  // Read response
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_valid <= 1'b0;
      r_read_instr <= '0;
    end else begin
      r_read_valid <= 1'b0;
      if (w_accept && w_hit) begin
        r_read_valid <= 1'b1;
        r_read_instr <= w_hit_instr;
      end else if (w_fill_done) begin
        r_read_valid <= 1'b1;
        r_read_instr <= w_fill_instr;
      end
    end
  end

  assign out_req_read_valid = r_read_valid;
  assign out_req_read_instr = r_read_instr;

endmodule

// File: tb/tb_snow64_instr_cache_param.sv
// ---------------------------------------------------------------------------
// tb_snow64_instr_cache_param
//
// Self-checking bench for snow64_instr_cache_param at default parameters.
// Backing memory is a pure function of the byte address; the cache model is
// a table of which line address is resident in each slot.
// ---------------------------------------------------------------------------
module tb_snow64_instr_cache_param;

  logic         clk;
  logic         rst;
  logic         in_req_read_req;
  logic [63:0]  in_req_read_addr;
  logic         in_flush_req;
  logic         in_mem_access_valid;
  logic [255:0] in_mem_access_data;
  logic         out_req_read_valid;
  logic [31:0]  out_req_read_instr;
  logic         out_busy;
  logic         out_mem_access_req;
  logic [63:0]  out_mem_access_addr;

  int n_tests;
  int n_fail;

  // Cache model: residency per slot
  bit          m_valid [32];
  logic [63:0] m_line  [32];

  snow64_instr_cache_param dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_req_read_req     (in_req_read_req),
    .in_req_read_addr    (in_req_read_addr),
    .in_flush_req        (in_flush_req),
    .in_mem_access_valid (in_mem_access_valid),
    .in_mem_access_data  (in_mem_access_data),
    .out_req_read_valid  (out_req_read_valid),
    .out_req_read_instr  (out_req_read_instr),
    .out_busy            (out_busy),
    .out_mem_access_req  (out_mem_access_req),
    .out_mem_access_addr (out_mem_access_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory contents
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    w = a >> 2;
    return (w[31:0] * 32'h9E3779B1) ^ w[63:32] ^ 32'hC3A50F1E;
  endfunction

  function automatic logic [255:0] line_data(input logic [63:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = mem_word(a + 64'(i * 4));
    return d;
  endfunction

  function automatic logic [63:0] align(input logic [63:0] a);
    return a & ~64'h1F;
  endfunction

  function automatic int slot(input logic [63:0] a);
    logic [63:0] s;
    s = (a >> 5) & 64'h1F;
    return int'(s);
  endfunction

  function automatic bit model_hit(input logic [63:0] a);
    return m_valid[slot(a)] && (m_line[slot(a)] == align(a));
  endfunction

  task automatic model_fill(input logic [63:0] a);
    m_valid[slot(a)] = 1'b1;
    m_line[slot(a)]  = align(a);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
  endtask

  // Issue one read and serve the fill (if any) after lat cycles of request.
  // Returns observations only; callers compare.
  task automatic read_txn(input logic [63:0] addr, input int lat,
                          output bit miss, output logic [63:0] fill_addr,
                          output int vlat, output logic [31:0] instr,
                          output bit stable);
    int first;
    miss = 1'b0; fill_addr = '0; vlat = -1; instr = '0; stable = 1'b1; first = -1;
    @(negedge clk);
    in_req_read_req  = 1'b1;
    in_req_read_addr = addr;
    @(posedge clk);
    @(negedge clk);
    in_req_read_req = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      in_mem_access_valid = 1'b0;
      if (out_req_read_valid) begin
        vlat  = k;
        instr = out_req_read_instr;
        break;
      end
      if (out_mem_access_req) begin
        if (first < 0) begin
          first = k; miss = 1'b1; fill_addr = out_mem_access_addr;
        end else if (out_mem_access_addr !== fill_addr) begin
          stable = 1'b0;
        end
        if (k == first + lat) begin
          in_mem_access_valid = 1'b1;
          in_mem_access_data  = line_data(fill_addr);
        end
      end
      @(negedge clk);
    end
    in_mem_access_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (out_req_read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_req_read_valid); end
    n_tests++; if (out_req_read_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", out_req_read_instr); end
    n_tests++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
    n_tests++; if (out_mem_access_req !== 1'b0) begin n_fail++; $display("FAIL reset_memreq got=%b exp=0", out_mem_access_req); end
    n_tests++; if (out_mem_access_addr !== 64'h0) begin n_fail++; $display("FAIL reset_memaddr got=%h exp=0", out_mem_access_addr); end
    rst = 1'b0;
    model_clear();
    $display("[TB] reset checked");
  endtask

  task automatic test_cold_miss_hit();
    bit miss, stable; logic [63:0] fa; int vlat; logic [31:0] ins;
    read_txn(64'h1004, 3, miss, fa, vlat, ins, stable);
    n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL cold_miss got=%b exp=1", miss); end
    n_tests++; if (fa !== 64'h1000) begin n_fail++; $display("FAIL cold_fill_addr got=%h exp=%h", fa, 64'h1000); end
    n_tests++; if (vlat != 5) begin n_fail++; $display("FAIL cold_latency got=%0d exp=5", vlat); end
    n_tests++; if (ins !== mem_word(64'h1004)) begin n_fail++; $display("FAIL cold_instr got=%h exp=%h", ins, mem_word(64'h1004)); end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL cold_addr_stable got=%b exp=1", stable); end
    model_fill(64'h1004);
    $display("[TB] cold read 0x1004 miss=%b lat=%0d instr=%h", miss, vlat, ins);
    read_txn(64'h1008, 3, miss, fa, vlat, ins, stable);
    n_tests++; if (miss !== 1'b0) begin n_fail++; $display("FAIL hit_miss got=%b exp=0", miss); end
    n_tests++; if (vlat != 1) begin n_fail++; $display("FAIL hit_latency got=%0d exp=1", vlat); end
    n_tests++; if (ins !== mem_word(64'h1008)) begin n_fail++; $display("FAIL hit_instr got=%h exp=%h", ins, mem_word(64'h1008)); end
    $display("[TB] re-read 0x1008 miss=%b lat=%0d instr=%h", miss, vlat, ins);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_req_read_req  = 1'b1;
    in_req_read_addr = 64'h1000;
    for (int w = 0; w < 8; w++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++; if (out_req_read_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%b exp=1", w, out_req_read_valid); end
      n_tests++; if (out_req_read_instr !== mem_word(64'h1000 + 64'(w * 4))) begin
        n_fail++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", w, out_req_read_instr, mem_word(64'h1000 + 64'(w * 4)));
      end
      $display("[TB] b2b word %0d instr=%h", w, out_req_read_instr);
      if (w < 7) in_req_read_addr = 64'h1000 + 64'((w + 1) * 4);
      else in_req_read_req = 1'b0;
    end
  endtask

  task automatic test_conflict();
    bit miss, stable; logic [63:0] fa; int vlat; logic [31:0] ins;
    read_txn(64'h1400, 2, miss, fa, vlat, ins, stable);
    n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL conflict_miss1 got=%b exp=1", miss); end
    n_tests++; if (ins !== mem_word(64'h1400)) begin n_fail++; $display("FAIL conflict_instr1 got=%h exp=%h", ins, mem_word(64'h1400)); end
    model_fill(64'h1400);
    $display("[TB] conflict read 0x1400 miss=%b instr=%h", miss, ins);
    read_txn(64'h1000, 1, miss, fa, vlat, ins, stable);
    n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL conflict_miss2 got=%b exp=1", miss); end
    n_tests++; if (vlat != 3) begin n_fail++; $display("FAIL conflict_latency2 got=%0d exp=3", vlat); end
    model_fill(64'h1000);
    $display("[TB] conflict re-read 0x1000 miss=%b lat=%0d", miss, vlat);
  endtask

  task automatic test_random();
    bit miss, stable, exp_hit; logic [63:0] fa, a; int vlat, lat, exp_lat; logic [31:0] ins;
    for (int it = 0; it < 24; it++) begin
      a   = (64'($urandom_range(16'h10, 16'h12)) << 10) | (64'($urandom_range(0, 7)) << 5) | (64'($urandom_range(0, 7)) << 2);
      lat = $urandom_range(0, 4);
      exp_hit = model_hit(a);
      exp_lat = exp_hit ? 1 : lat + 2;
      read_txn(a, lat, miss, fa, vlat, ins, stable);
      n_tests++; if (miss !== !exp_hit) begin n_fail++; $display("FAIL rand_miss addr=%h got=%b exp=%b", a, miss, !exp_hit); end
      n_tests++; if (vlat != exp_lat) begin n_fail++; $display("FAIL rand_latency addr=%h got=%0d exp=%0d", a, vlat, exp_lat); end
      n_tests++; if (ins !== mem_word(a)) begin n_fail++; $display("FAIL rand_instr addr=%h got=%h exp=%h", a, ins, mem_word(a)); end
      if (!exp_hit) begin
        n_tests++; if (fa !== align(a)) begin n_fail++; $display("FAIL rand_fill_addr got=%h exp=%h", fa, align(a)); end
        n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL rand_addr_stable got=%b exp=1", stable); end
        model_fill(a);
      end
      $display("[TB] rand addr=%h lat=%0d hit=%b vlat=%0d instr=%h", a, lat, exp_hit, vlat, ins);
    end
  endtask

  task automatic test_flush();
    bit miss, stable; logic [63:0] fa; int vlat, cnt; logic [31:0] ins;
    read_txn(64'h0000, 1, miss, fa, vlat, ins, stable); model_fill(64'h0000);
    read_txn(64'h03E0, 1, miss, fa, vlat, ins, stable); model_fill(64'h03E0);
    @(negedge clk);
    in_flush_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_flush_req = 1'b0;
    cnt = 0;
    while (out_busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    n_tests++; if (cnt != 32) begin n_fail++; $display("FAIL flush_busy_cycles got=%0d exp=32", cnt); end
    model_clear();
    $display("[TB] flush busy cycles=%0d", cnt);
    read_txn(64'h0000, 1, miss, fa, vlat, ins, stable);
    n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL flush_line0_miss got=%b exp=1", miss); end
    read_txn(64'h03E0, 1, miss, fa, vlat, ins, stable);
    n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL flush_line31_miss got=%b exp=1", miss); end
    model_fill(64'h0000); model_fill(64'h03E0);
    $display("[TB] post-flush reads of lines 0 and 31 done");
  endtask

  task automatic test_flush_during_fill();
    bit miss, stable, saw_low; logic [63:0] fa; int vlat, run; logic [31:0] ins;
    @(negedge clk);
    in_req_read_req  = 1'b1;
    in_req_read_addr = 64'h2004;
    @(posedge clk);
    @(negedge clk);
    in_req_read_req = 1'b0;
    vlat = -1; ins = '0; run = 0; saw_low = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      in_flush_req        = (k == 1);
      in_mem_access_valid = (k == 3) && out_mem_access_req;
      in_mem_access_data  = line_data(64'h2000);
      if (out_req_read_valid) begin vlat = k; ins = out_req_read_instr; end
      if (out_busy && !saw_low) run++;
      else saw_low = 1'b1;
      @(negedge clk);
    end
    in_flush_req = 1'b0;
    in_mem_access_valid = 1'b0;
    n_tests++; if (vlat != 4) begin n_fail++; $display("FAIL pend_latency got=%0d exp=4", vlat); end
    n_tests++; if (ins !== mem_word(64'h2004)) begin n_fail++; $display("FAIL pend_instr got=%h exp=%h", ins, mem_word(64'h2004)); end
    n_tests++; if (run != 35) begin n_fail++; $display("FAIL pend_busy_run got=%0d exp=35", run); end
    model_clear();
    $display("[TB] flush during fill vlat=%0d busy_run=%0d", vlat, run);
    read_txn(64'h2004, 1, miss, fa, vlat, ins, stable);
    n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL pend_line_miss got=%b exp=1", miss); end
    model_fill(64'h2004);
  endtask

  task automatic test_read_flush_same_cycle();
    bit sawv; int cnt;
    @(negedge clk);
    in_req_read_req  = 1'b1;
    in_req_read_addr = 64'h2000;
    in_flush_req     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_req_read_req = 1'b0;
    in_flush_req    = 1'b0;
    n_tests++; if (out_req_read_valid !== 1'b0) begin n_fail++; $display("FAIL rf_valid got=%b exp=0", out_req_read_valid); end
    n_tests++; if (out_busy !== 1'b1) begin n_fail++; $display("FAIL rf_busy got=%b exp=1", out_busy); end
    n_tests++; if (out_mem_access_req !== 1'b0) begin n_fail++; $display("FAIL rf_memreq got=%b exp=0", out_mem_access_req); end
    sawv = 1'b0; cnt = 0;
    while (out_busy && cnt < 100) begin
      if (out_req_read_valid) sawv = 1'b1;
      cnt++;
      @(negedge clk);
    end
    n_tests++; if (sawv !== 1'b0) begin n_fail++; $display("FAIL rf_no_valid got=%b exp=0", sawv); end
    n_tests++; if (cnt != 32) begin n_fail++; $display("FAIL rf_walk_cycles got=%0d exp=32", cnt); end
    model_clear();
    $display("[TB] read+flush same cycle walk=%0d valid_seen=%b", cnt, sawv);
  endtask

  task automatic test_reset_mid_fill();
    bit miss, stable, sawv; logic [63:0] fa; int vlat; logic [31:0] ins;
    read_txn(64'h1000, 1, miss, fa, vlat, ins, stable); model_fill(64'h1000);
    read_txn(64'h1020, 2, miss, fa, vlat, ins, stable); model_fill(64'h1020);
    @(negedge clk);
    in_req_read_req  = 1'b1;
    in_req_read_addr = 64'h5044;
    @(posedge clk);
    @(negedge clk);
    in_req_read_req = 1'b0;
    n_tests++; if (out_mem_access_req !== 1'b1) begin n_fail++; $display("FAIL rmf_req_before got=%b exp=1", out_mem_access_req); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (out_mem_access_req !== 1'b0) begin n_fail++; $display("FAIL rmf_req_after got=%b exp=0", out_mem_access_req); end
    n_tests++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL rmf_busy got=%b exp=0", out_busy); end
    sawv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_mem_access_valid = (k == 1);
      in_mem_access_data  = line_data(64'h5040);
      if (out_req_read_valid) sawv = 1'b1;
      @(negedge clk);
    end
    in_mem_access_valid = 1'b0;
    n_tests++; if (sawv !== 1'b0) begin n_fail++; $display("FAIL rmf_no_valid got=%b exp=0", sawv); end
    model_clear();
    read_txn(64'h1000, 1, miss, fa, vlat, ins, stable);
    n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL rmf_line_a_miss got=%b exp=1", miss); end
    read_txn(64'h1020, 1, miss, fa, vlat, ins, stable);
    n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL rmf_line_b_miss got=%b exp=1", miss); end
    model_fill(64'h1000); model_fill(64'h1020);
    $display("[TB] reset mid-fill handled, valid_seen=%b", sawv);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst                 = 1'b1;
    in_req_read_req     = 1'b0;
    in_req_read_addr    = '0;
    in_flush_req        = 1'b0;
    in_mem_access_valid = 1'b0;
    in_mem_access_data  = '0;
    model_clear();
    test_reset();
    test_cold_miss_hit();
    test_back_to_back();
    test_conflict();
    test_random();
    test_flush();
    test_flush_during_fill();
    test_read_flush_same_cycle();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
